// File: rtl/bus_mux_arbiter.sv
// rtl/bus_mux_arbiter.sv - fixed-priority bus multiplexer with conflict detection and counting
module bus_mux_arbiter #(
  parameter int DATA_W    = 32,
  parameter int N_SRC     = 24,
  parameter int SEL_W     = 5,
  parameter int REG_OUT   = 1,
  parameter int IDLE_MODE = 0,
  parameter int CNT_W     = 8
) (
  input  logic                    clock,
  input  logic                    clear_n,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  input  logic [N_SRC-1:0]        src_out,
  input  logic                    err_clr,
  output logic [DATA_W-1:0]       bus_out,
  output logic                    bus_valid,
  output logic [SEL_W-1:0]        bus_owner,
  output logic                    conflict,
  output logic                    conflict_sticky,
  output logic [CNT_W-1:0]        conflict_cnt
);

  logic              any;
  logic              multi;
  logic [SEL_W-1:0]  win_idx;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] next_out;
  logic [DATA_W-1:0] last_val;

  assign any   = |src_out;
  // Clearing the lowest set bit leaves something behind only if two or more bits were set.
  assign multi = (src_out & (src_out - N_SRC'(1))) != '0;

  // Priority encoder: scan from the top down so the lowest set index is the last to win.
  always_comb begin
    win_idx  = '0;
    sel_data = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (src_out[i]) begin
        win_idx  = SEL_W'(i);
        sel_data = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Value the bus should carry for the current inputs, including the idle policy.
  always_comb begin
    next_out = '0;
    if (any)
      next_out = sel_data;
    else if (IDLE_MODE != 0)
      next_out = last_val;
  end

  // Remember the most recently driven value for the hold-on-idle policy.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n)
      last_val <= '0;
    else if (any)
      last_val <= sel_data;
  end

  // Sticky flag and saturating counter; err_clr wins over a same-cycle conflict.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      conflict_sticky <= 1'b0;
      conflict_cnt    <= '0;
    end else if (err_clr) begin
      conflict_sticky <= 1'b0;
      conflict_cnt    <= '0;
    end else if (multi) begin
      conflict_sticky <= 1'b1;
      if (!(&conflict_cnt))
        conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg
      // Registered outputs: one cycle of latency; in-flight data is dropped on reset.
      always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
          bus_out   <= '0;
          bus_valid <= 1'b0;
          bus_owner <= '0;
          conflict  <= 1'b0;
        end else begin
          bus_out   <= next_out;
          bus_valid <= any;
          bus_owner <= win_idx;
          conflict  <= multi;
        end
      end
    end else begin : g_comb
      assign bus_out   = next_out;
      assign bus_valid = any;
      assign bus_owner = win_idx;
      assign conflict  = multi;
    end
  endgenerate

endmodule

// File: tb/tb_bus_mux_arbiter.sv
// tb/tb_bus_mux_arbiter.sv - self-checking bench for bus_mux_arbiter
module tb_bus_mux_arbiter;

  logic         clk = 1'b0;
  logic         clear_n = 1'b1;
  logic [767:0] src_data = '0;
  logic [23:0]  src_out = '0;
  logic         err_clr = 1'b0;
  logic [31:0]  c_data = '0;
  logic [3:0]   c_src = '0;

  logic [31:0] a_bus_out, b_bus_out;
  logic        a_valid, b_valid, a_conf, b_conf, a_sticky, b_sticky;
  logic [4:0]  a_owner, b_owner;
  logic [7:0]  a_cnt, b_cnt;
  logic [7:0]  c_bus_out;
  logic        c_valid, c_conf, c_sticky;
  logic [1:0]  c_owner;
  logic [7:0]  c_cnt;

  int checks = 0;
  int failures = 0;
  bit run = 1'b0;

  bus_mux_arbiter #(.IDLE_MODE(0)) dut_a (
    .clock(clk), .clear_n(clear_n), .src_data(src_data), .src_out(src_out), .err_clr(err_clr),
    .bus_out(a_bus_out), .bus_valid(a_valid), .bus_owner(a_owner), .conflict(a_conf),
    .conflict_sticky(a_sticky), .conflict_cnt(a_cnt));

  bus_mux_arbiter #(.IDLE_MODE(1)) dut_b (
    .clock(clk), .clear_n(clear_n), .src_data(src_data), .src_out(src_out), .err_clr(err_clr),
    .bus_out(b_bus_out), .bus_valid(b_valid), .bus_owner(b_owner), .conflict(b_conf),
    .conflict_sticky(b_sticky), .conflict_cnt(b_cnt));

  bus_mux_arbiter #(.DATA_W(8), .N_SRC(4), .SEL_W(2), .REG_OUT(0)) dut_c (
    .clock(clk), .clear_n(clear_n), .src_data(c_data), .src_out(c_src), .err_clr(err_clr),
    .bus_out(c_bus_out), .bus_valid(c_valid), .bus_owner(c_owner), .conflict(c_conf),
    .conflict_sticky(c_sticky), .conflict_cnt(c_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Index of the lowest set bit: isolate it with v & -v, then take its log2.
  function automatic int lowest(input logic [23:0] v);
    logic [23:0] iso;
    iso = v & (~v + 24'd1);
    return $clog2(iso);
  endfunction

  function automatic logic [31:0] data_of(input logic [23:0] v);
    int k;
    k = lowest(v);
    return src_data[k*32 +: 32];
  endfunction

  // Reference model for the two registered instances.
  logic [31:0] m_out_a = '0, m_out_b = '0, m_last = '0;
  logic        m_valid = 1'b0, m_conf = 1'b0, m_sticky = 1'b0;
  logic [4:0]  m_owner = '0;
  int          m_cnt = 0;

  always @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      m_out_a <= '0; m_out_b <= '0; m_last <= '0;
      m_valid <= 1'b0; m_conf <= 1'b0; m_sticky <= 1'b0;
      m_owner <= '0; m_cnt <= 0;
    end else begin
      m_valid <= (src_out != 0);
      m_owner <= (src_out != 0) ? 5'(lowest(src_out)) : 5'd0;
      m_conf  <= ($countones(src_out) > 1);
      m_out_a <= (src_out != 0) ? data_of(src_out) : 32'd0;
      m_out_b <= (src_out != 0) ? data_of(src_out) : m_last;
      if (src_out != 0) m_last <= data_of(src_out);
      if (err_clr) begin
        m_sticky <= 1'b0;
        m_cnt    <= 0;
      end else if ($countones(src_out) > 1) begin
        m_sticky <= 1'b1;
        m_cnt    <= (m_cnt < 255) ? m_cnt + 1 : 255;
      end
    end
  end

  // Per-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    if (run) begin
      chk("a_bus_out", a_bus_out, m_out_a);
      chk("a_valid", a_valid, m_valid);
      chk("a_owner", a_owner, m_owner);
      chk("a_conflict", a_conf, m_conf);
      chk("a_sticky", a_sticky, m_sticky);
      chk("a_cnt", a_cnt, 64'(m_cnt));
      chk("b_bus_out", b_bus_out, m_out_b);
      chk("b_valid", b_valid, m_valid);
      chk("b_owner", b_owner, m_owner);
      chk("c_bus_out", c_bus_out, (c_src != 0) ? 64'(c_data[$clog2(c_src & (~c_src + 4'd1))*8 +: 8]) : 64'd0);
      chk("c_valid", c_valid, c_src != 0);
      chk("c_owner", c_owner, (c_src != 0) ? 64'($clog2(c_src & (~c_src + 4'd1))) : 64'd0);
      chk("c_conflict", c_conf, $countones(c_src) > 1);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    src_data = '0;
    src_out  = '0;
    err_clr  = 1'b0;
  endtask

  logic [23:0] vec_tbl [6] = '{24'h000000, 24'h800000, 24'h000300, 24'hFFFFFF, 24'h400001, 24'h010000};
  logic [7:0]  c_exp   [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

  initial begin
    #1 clear_n = 1'b0;
    next_cycle();
    next_cycle();
    clear_n = 1'b1;
    run = 1'b1;

    // Reset mid-transfer: outputs drop immediately, before any edge.
    src_out = 24'h000020;
    src_data[5*32 +: 32] = 32'hDEADBEEF;
    next_cycle();
    chk("t1_pre_out", a_bus_out, 64'hDEADBEEF);
    #1 clear_n = 1'b0;
    #1;
    chk("t1_out", a_bus_out, 0);
    chk("t1_valid", a_valid, 0);
    chk("t1_owner", a_owner, 0);
    chk("t1_cnt", a_cnt, 0);
    chk("t1_b_out", b_bus_out, 0);
    next_cycle();
    clear_n = 1'b1;
    clear_inputs();
    next_cycle();

    // Single driver: MDR (source 21).
    src_out = 24'd1 << 21;
    src_data[21*32 +: 32] = 32'h12345678;
    @(posedge clk); #1;
    chk("t2_out", a_bus_out, 64'h12345678);
    chk("t2_owner", a_owner, 21);
    chk("t2_valid", a_valid, 1);
    chk("t2_conflict", a_conf, 0);
    #1;
    clear_inputs();

    // Conflict between sources 3 and 17, then saturation.
    src_out = (24'd1 << 3) | (24'd1 << 17);
    src_data[3*32 +: 32]  = 32'hA;
    src_data[17*32 +: 32] = 32'hB;
    @(posedge clk); #1;
    chk("t3_out", a_bus_out, 64'hA);
    chk("t3_owner", a_owner, 3);
    chk("t3_conflict", a_conf, 1);
    chk("t3_sticky", a_sticky, 1);
    chk("t3_cnt", a_cnt, 1);
    repeat (299) @(posedge clk);
    #1;
    chk("t3_cnt_sat", a_cnt, 255);
    #1;

    // err_clr with a simultaneous conflict: clear wins, conflict still shows.
    err_clr = 1'b1;
    @(posedge clk); #1;
    chk("t4_sticky", a_sticky, 0);
    chk("t4_cnt", a_cnt, 0);
    chk("t4_conflict", a_conf, 1);
    #1;
    clear_inputs();

    // Idle policy: drive 0x55 from source 0, then release.
    src_out = 24'd1;
    src_data[31:0] = 32'h55;
    next_cycle();
    src_out = '0;
    @(posedge clk); #1;
    chk("t5_a_out", a_bus_out, 0);
    chk("t5_b_out", b_bus_out, 64'h55);
    chk("t5_a_valid", a_valid, 0);
    chk("t5_b_valid", b_valid, 0);
    chk("t5_a_owner", a_owner, 0);
    chk("t5_b_owner", b_owner, 0);
    #1;

    // Directed patterns checked by the per-cycle model.
    for (int v = 0; v < 6; v++) begin
      for (int s = 0; s < 24; s++) src_data[s*32 +: 32] = 32'h1000_0000 + 32'(s * 257 + v);
      src_out = vec_tbl[v];
      next_cycle();
    end
    clear_inputs();
    next_cycle();

    // Combinational instance: every single-hot source appears in the same cycle.
    c_data = 32'hD3C2B1A0;
    for (int i = 0; i < 4; i++) begin
      c_src = 4'(1 << i);
      #1;
      chk("t6_out", c_bus_out, 64'(c_exp[i]));
      chk("t6_owner", c_owner, 64'(i));
      next_cycle();
    end
    c_src = 4'b1010;
    #1;
    chk("t6_conflict_out", c_bus_out, 64'hB1);
    next_cycle();
    c_src = '0;
    next_cycle();

    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
